// File: rtl/fiber_pattern_gen.sv
// fiber_pattern_gen: transmit-side 16-bit test-pattern source for the optical link.
// Emits counter / walking-one / PRBS15 / fixed words, optionally in bursts
// separated by idle gaps, with single-word bit0 error injection for checker self-test.
module fiber_pattern_gen #(
  parameter int DATA_W = 16,
  parameter int GAP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [15:0]       burst_len,
  input  logic [GAP_W-1:0]  gap_len,
  input  logic              inject_err,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic [31:0]       words_sent,
  output logic [15:0]       err_injected
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam logic [1:0]       MODE_CNT   = 2'd0;
  localparam logic [1:0]       MODE_WALK  = 2'd1;
  localparam logic [1:0]       MODE_PRBS  = 2'd2;
  localparam logic [1:0]       MODE_FIXED = 2'd3;
  localparam logic [GAP_W-1:0] GAP_ONE    = GAP_W'(1);

  // Generator start value; walking-one and PRBS must never start from all-zero
  // or they would lock up.
  function automatic logic [DATA_W-1:0] gen_load(input logic [1:0] m, input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] r;
    case (m)
      MODE_CNT:   r = s;
      MODE_WALK:  r = (s == 16'h0000) ? 16'h0001 : s;
      MODE_PRBS:  r = (s[14:0] == 15'h0000) ? 16'h0001 : {1'b0, s[14:0]};
      MODE_FIXED: r = s;
      default:    r = s;
    endcase
    return r;
  endfunction

  // Generator step for one transmitted word.
  function automatic logic [DATA_W-1:0] gen_advance(input logic [1:0] m, input logic [DATA_W-1:0] g);
    logic [DATA_W-1:0] r;
    case (m)
      MODE_CNT:   r = g + 16'h0001;
      MODE_WALK:  r = {g[14:0], g[15]};
      MODE_PRBS:  r = {1'b0, g[13:0], g[14] ^ g[13]};
      MODE_FIXED: r = g;
      default:    r = g;
    endcase
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [15:0]       burst_len_q, burst_len_d;
  logic [GAP_W-1:0]  gap_len_q, gap_len_d;
  logic [DATA_W-1:0] gen_q, gen_d;
  logic [15:0]       burst_cnt_q, burst_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              pending_q, pending_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              busy_q, busy_d;
  logic [31:0]       words_sent_q, words_sent_d;
  logic [15:0]       err_injected_q, err_injected_d;
  logic              consume_s;
  logic [15:0]       burst_cnt_inc_s;
  logic [GAP_W-1:0]  gap_cnt_inc_s;

  assign burst_cnt_inc_s = burst_cnt_q + 16'h0001;
  assign gap_cnt_inc_s   = gap_cnt_q + GAP_ONE;

  // Next-state, datapath and output computation for the IDLE/LOAD/RUN/GAP sequencer.
  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    burst_len_d    = burst_len_q;
    gap_len_d      = gap_len_q;
    gen_d          = gen_q;
    burst_cnt_d    = burst_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    data_out_d     = data_out_q;
    data_valid_d   = 1'b0;
    words_sent_d   = words_sent_q;
    err_injected_d = err_injected_q;
    consume_s      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        mode_d      = mode;
        burst_len_d = burst_len;
        gap_len_d   = gap_len;
        gen_d       = gen_load(mode, seed);
        burst_cnt_d = 16'h0000;
        gap_cnt_d   = {GAP_W{1'b0}};
        state_d     = ST_RUN;
      end

      ST_RUN: begin
        // Injection flips bit0 of the outgoing word only; gen keeps its true sequence.
        consume_s    = pending_q;
        data_out_d   = gen_q ^ {{(DATA_W-1){1'b0}}, pending_q};
        data_valid_d = 1'b1;
        gen_d        = gen_advance(mode_q, gen_q);
        words_sent_d = words_sent_q + 32'd1;
        burst_cnt_d  = burst_cnt_inc_s;
        gap_cnt_d    = {GAP_W{1'b0}};
        if (pending_q && (err_injected_q != 16'hFFFF)) begin
          err_injected_d = err_injected_q + 16'h0001;
        end else begin
          err_injected_d = err_injected_q;
        end
        if (!enable) begin
          state_d = ST_IDLE;
        end else if ((burst_len_q != 16'h0000) && (burst_cnt_inc_s == burst_len_q)) begin
          burst_cnt_d = 16'h0000;
          if (gap_len_q != {GAP_W{1'b0}}) begin
            state_d = ST_GAP;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_GAP: begin
        if (gap_cnt_inc_s == gap_len_q) begin
          gap_cnt_d = {GAP_W{1'b0}};
          if (enable) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_inc_s;
          state_d   = ST_GAP;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new pulse always re-arms, even on the edge that consumes the old flag.
    pending_d = inject_err | (pending_q & ~consume_s);
    busy_d    = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      mode_q         <= 2'd0;
      burst_len_q    <= 16'h0000;
      gap_len_q      <= {GAP_W{1'b0}};
      gen_q          <= {DATA_W{1'b0}};
      burst_cnt_q    <= 16'h0000;
      gap_cnt_q      <= {GAP_W{1'b0}};
      pending_q      <= 1'b0;
      data_out_q     <= {DATA_W{1'b0}};
      data_valid_q   <= 1'b0;
      busy_q         <= 1'b0;
      words_sent_q   <= 32'd0;
      err_injected_q <= 16'h0000;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      burst_len_q    <= burst_len_d;
      gap_len_q      <= gap_len_d;
      gen_q          <= gen_d;
      burst_cnt_q    <= burst_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      pending_q      <= pending_d;
      data_out_q     <= data_out_d;
      data_valid_q   <= data_valid_d;
      busy_q         <= busy_d;
      words_sent_q   <= words_sent_d;
      err_injected_q <= err_injected_d;
    end
  end

  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign busy         = busy_q;
  assign words_sent   = words_sent_q;
  assign err_injected = err_injected_q;

endmodule
